// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests; otherwise low address bits are ignored.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
    state_t state, state_next;
    logic        wr, sgn, hs, mis, word, half;
    logic [1:0]  size;
    logic [4:0]  shamt;
    logic [15:0] lane;
    logic [31:0] addr, wdata, old_word, load_data, mask, merged;

    assign hs = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign word  = size[1];
    assign half  = size == 2'b01;
    assign shamt = half ? {addr[1], 4'b0000} : {addr[1:0], 3'b000};
    assign lane  = 16'(mem_read_data >> shamt);
    assign load_data = word ? mem_read_data
                     : half ? {{16{sgn & lane[15]}}, lane}
                     : {{24{sgn & lane[7]}}, lane[7:0]};
    assign mask   = (half ? 32'h0000_ffff : 32'h0000_00ff) << shamt;
    assign merged = (old_word & ~mask) | ((half ? {2{wdata[15:0]}} : {4{wdata[7:0]}}) & mask);

    // memory side decodes only from registered state and the latched request
    assign req_ready      = state == IDLE;
    assign resp_valid     = state == RESP;
    assign mem_address    = {addr[31:2], 2'b00};
    assign mem_write      = state == MERGE || (state == ACCESS && wr && word);
    assign mem_write_data = state == MERGE ? merged : wdata;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   state_next = hs ? (mis ? RESP : ACCESS) : IDLE;
            ACCESS: state_next = (wr && !word) ? MERGE : RESP;
            MERGE:  state_next = RESP;
            RESP:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr         <= 1'b0;
            size       <= 2'b00;
            sgn        <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            old_word   <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            state <= state_next;
            if (hs) begin
                wr         <= req_write;
                size       <= req_size;
                sgn        <= req_signed;
                addr       <= req_addr;
                wdata      <= req_wdata;
                resp_error <= mis;
                if (mis)
                    resp_rdata <= '0;
            end
            if (state == ACCESS) begin
                old_word <= mem_read_data;
                if (!wr)
                    resp_rdata <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests against a byte-array reference model.
module tb_load_store_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_error, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic [31:0] mem [1024];
    logic [7:0]  ref_mem [4096];
    logic [31:0] last_rdata = '0;
    logic [31:0] q_rd [$];
    logic        q_er [$];
    int n_cmp = 0, n_bad = 0;
    int acc, nresp, bad_words;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_address[11:2]];
    always @(posedge clk) if (mem_write) mem[mem_address[11:2]] <= mem_write_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
    endfunction

    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er,
                         output int rcyc, output int nw);
        int nb;
        logic [11:0] base;
        logic [31:0] v;
        nb = sz[1] ? 4 : sz[0] ? 2 : 1;
        er = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        er = (int'(a[1:0]) % nb) != 0;
`endif
        if (er) begin
            last_rdata = '0;
            rd = '0;
            rcyc = 1;
            nw = 0;
            return;
        end
        base = a[11:0] - 12'(int'(a[1:0]) % nb);
        if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[base + 12'(i)] = d[8*i +: 8];
            nw = 1;
            rcyc = nb == 4 ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[base + 12'(i)];
            if (sg && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hff;
            last_rdata = v;
            nw = 0;
            rcyc = 2;
        end
        rd = last_rdata;
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d);
        logic [31:0] erd, waddr;
        logic eer;
        int ercyc, enw, rcyc, nw, wcyc;
        model(w, sz, sg, a, d, erd, eer, ercyc, enw);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rcyc = 0; nw = 0; wcyc = 0; waddr = '0;
        for (int k = 1; k <= 8 && rcyc == 0; k++) begin
            @(negedge clk);
            if (mem_write) begin nw++; wcyc = k; waddr = mem_address; end
            if (resp_valid) begin
                rcyc = k;
                check({tag, " rdata"}, resp_rdata, erd);
                check({tag, " error"}, 32'(resp_error), 32'(eer));
            end
        end
        check({tag, " resp_cycle"}, rcyc, ercyc);
        check({tag, " writes"}, nw, enw);
        if (enw != 0) begin
            check({tag, " write_cycle"}, wcyc, ercyc - 1);
            check({tag, " write_addr"}, waddr, {a[31:2], 2'b00});
        end
        check({tag, " mem_word"}, mem[a[11:2]], ref_word(a));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]} = mem[i];
        end
        #12;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_error", 32'(resp_error), 32'd0);
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst mem_address", mem_address, 32'd0);
        check("rst mem_write_data", mem_write_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_req("st_w", 1'b1, 2'd2, 1'b0, 32'h10, 32'hdeadbeef);
        do_req("ld_w", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("plan ld_w", resp_rdata, 32'hdeadbeef);
        do_req("st_w20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        do_req("st_b22", 1'b1, 2'd0, 1'b0, 32'h22, 32'h000000aa);
        check("plan rmw byte", mem[8], 32'h11aa3344);
        do_req("ld_sb", 1'b0, 2'd0, 1'b1, 32'h22, 32'h0);
        check("plan ld_sb", resp_rdata, 32'hffffffaa);
        do_req("ld_ub", 1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
        check("plan ld_ub", resp_rdata, 32'h000000aa);
        do_req("st_w30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h0);
        do_req("st_h32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h00008001);
        check("plan rmw half", mem[12], 32'h80010000);
        do_req("ld_sh", 1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
        check("plan ld_sh", resp_rdata, 32'hffff8001);
        do_req("ld_mis", 1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("plan mis rdata", resp_rdata, 32'h0);
        check("plan mis error", 32'(resp_error), 32'd1);
`else
        check("plan mis rdata", resp_rdata, mem[16]);
`endif

        for (int i = 0; i < 150; i++)
            do_req("rand", 1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 4095)), $urandom);

        acc = 0; nresp = 0;
        for (int c = 0; c < 80; c++) begin
            logic [31:0] erd;
            logic eer;
            int ercyc, enw;
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                if (q_rd.size() > 0) begin
                    check("hs rdata", resp_rdata, q_rd.pop_front());
                    check("hs error", 32'(resp_error), 32'(q_er.pop_front()));
                end else
                    check("hs spurious resp", 32'(resp_valid), 32'd0);
            end
            req_valid = 1'b1; req_write = 1'($urandom); req_size = 2'($urandom);
            req_signed = 1'($urandom); req_addr = 32'($urandom_range(0, 255)); req_wdata = $urandom;
            if (req_ready) begin
                model(req_write, req_size, req_signed, req_addr, req_wdata, erd, eer, ercyc, enw);
                q_rd.push_back(erd);
                q_er.push_back(eer);
                acc++;
            end
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                nresp++;
                if (q_rd.size() > 0) begin
                    check("hs rdata", resp_rdata, q_rd.pop_front());
                    check("hs error", 32'(resp_error), 32'(q_er.pop_front()));
                end else
                    check("hs spurious resp", 32'(resp_valid), 32'd0);
            end
        end
        check("hs resp count", nresp, acc);
        bad_words = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_word(32'(4*i))) bad_words++;
        check("mem image", bad_words, 0);

        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h52; req_wdata = 32'h5a;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst merge mem_write", 32'(mem_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst async mem_write", 32'(mem_write), 32'd0);
        check("rst async resp_valid", 32'(resp_valid), 32'd0);
        check("rst async req_ready", 32'(req_ready), 32'd1);
        check("rst async resp_rdata", resp_rdata, 32'd0);
        check("rst async resp_error", 32'(resp_error), 32'd0);
        check("rst async mem_address", mem_address, 32'd0);
        check("rst async mem_write_data", mem_write_data, 32'd0);
        @(posedge clk);
        #1 check("rst mem unchanged", mem[20], ref_word(32'h50));
        @(negedge clk) rst_n = 1'b1;
        last_rdata = '0;
        nresp = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        check("rst no resp", nresp, 0);
        do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h50, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit between the CPU datapath and the word-organised data memory (1024 × 32-bit, word write, asynchronous read). It accepts one byte, halfword or word request at a time over a valid/ready handshake and drives the memory's `mem_write`/`address`/`write_data` inputs. It consumes `read_data` and returns aligned, optionally sign-extended load data. Sub-word stores become a read-modify-write sequence, because the memory writes only whole words.

## Interface
- No parameters. Address width 32, data width 32, byte order little-endian.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_signed` input 1: sign-extend loaded byte/half (ignored for stores and words).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle completion pulse (loads and stores).
- `resp_rdata` output 32: load result, valid with `resp_valid`, held until the next response.
- `resp_error` output 1: misaligned request, valid with `resp_valid`.
- `mem_write` output 1: memory write enable.
- `mem_address` output 32: memory address, word-aligned (bits [1:0] = 00).
- `mem_write_data` output 32: memory write data.
- `mem_read_data` input 32: memory read data, combinational from `mem_address`.

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESP.
- **IDLE**
  - Handshake is `req_valid && req_ready` at a clock edge.
  - On handshake, latch write, size, signed, addr and wdata.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]≠00): go to RESP with error set. No memory access occurs.
  - All other requests go to ACCESS.
- **ACCESS**
  - `mem_address` = {addr[31:2], 2'b00}.
  - Load: select the lane by addr[1:0] (byte) or addr[1] (half). Zero- or sign-extend it, register it into `resp_rdata`, then go to RESP.
  - Word store: `mem_write` = 1, `mem_write_data` = wdata, then go to RESP.
  - Sub-word store: capture `mem_read_data` into an old-word register, then go to MERGE.
- **MERGE** (sub-word store only)
  - `mem_write` = 1.
  - `mem_write_data` = old word with only the addressed byte or half replaced by wdata[7:0] or wdata[15:0]; all other bits are unchanged.
  - Next state is RESP.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle, then return to IDLE.
  - On a store, `resp_rdata` is unchanged.
- `mem_write`, `mem_address` and `mem_write_data` decode only from the state register and the latched request. There is no combinational path from any `req_*` input to a `mem_*` output.
- `mem_write` is high for exactly one cycle per store that is not misaligned, and never high otherwise.
- Requests presented while `req_ready` = 0 are ignored and are not latched.

## Timing
- Count from handshake edge N. The cycle after N is N+1.
  - Load: ACCESS in N+1; `resp_valid` in N+2.
  - Word store: `mem_write` in N+1; `resp_valid` in N+2.
  - Sub-word store: read in N+1; `mem_write` in N+2; `resp_valid` in N+3.
  - Misaligned (trap on): `resp_valid`/`resp_error` in N+1.
- `req_ready` returns high in the cycle after RESP.
- Peak throughput: one load every 3 cycles.
- Reset values: state IDLE, `req_ready` 1, and all of the following 0: `resp_valid`, `resp_rdata`, `resp_error`, `mem_write`, `mem_address`, `mem_write_data`.
- Reset asserted mid-operation forces `mem_write` low immediately (asynchronous). The in-flight request is dropped with no response, and any pending MERGE write is never issued.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - Misaligned requests complete with `resp_error` = 1 and perform no memory access.
  - Error responses drive `resp_rdata` to 0.
- Undefined:
  - No alignment check; low address bits are forced to alignment (half ignores addr[0]; word ignores addr[1:0]).
  - `resp_error` is tied to 0.

## Test plan
- Word store then load: store addr 0x10, data 0xDEADBEEF (`mem_write` one cycle in N+1, `mem_address` 0x10), then load word from 0x10 → `resp_rdata` 0xDEADBEEF in N+2.
- Byte store RMW: memory word at 0x20 holds 0x11223344; store byte 0xAA at 0x22 → MERGE writes 0x11AA3344. Then a signed byte load from 0x22 → 0xFFFFFFAA, and an unsigned byte load → 0x000000AA.
- Half store/load: at 0x30 holding 0x00000000, store half 0x8001 at 0x32 → 0x80010000. Then a signed half load from 0x32 → 0xFFFF8001.
- Misaligned (trap on): load word at 0x41 → `resp_error` = 1 and `resp_rdata` = 0 in N+1, `mem_write` never high. Trap off: the same load returns the word at 0x40.
- Handshake: hold `req_valid` = 1 continuously with changing requests → only requests sampled while `req_ready` = 1 are executed, with exactly one `resp_valid` per accepted request.
- Reset mid-store: assert `rst_n` = 0 during MERGE of a byte store → `mem_write` drops at once, the memory word is unchanged, all outputs take their reset values, and there is no response.
